attack_phase_sequencer: RTL and testbench

Sequences a fighter's attack through wind-up, active, and recovery phases, plus hit-stun. It acts as the initiator on the fraction-second timer interface: it drives `tmr_start`, `tmr_fraction` and `tmr_clear`, and consumes `tmr_done`, `tmr_running` and `tmr_halfway`. One instance sits per player, between the debounced button pulses and the sprite/hitbox logic.

---
 rtl/attack_pkg.sv | 33 +++
 rtl/attack_req_buffer.sv | 57 +++++
 rtl/attack_phase_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_attack_phase_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/attack_pkg.sv
// attack_pkg
// Shared definitions for the attack phase sequencer and its combo buffer.
//   phase_e  : phase codes driven on the `phase` output.
//   attack_e : attack type codes driven on the `attack_type` output.
//   DEF_*    : default timer fractions (denominators of one second).
package attack_pkg;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_WINDUP   = 3'd1,
        PH_ACTIVE   = 3'd2,
        PH_RECOVERY = 3'd3,
        PH_ABORT    = 3'd4,
        PH_STUN     = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        ATK_NONE  = 2'd0,
        ATK_PUNCH = 2'd1,
        ATK_KICK  = 2'd2
    } attack_e;

    localparam logic [3:0] DEF_P_WIND_FRAC = 4'd8;
    localparam logic [3:0] DEF_P_ACT_FRAC  = 4'd8;
    localparam logic [3:0] DEF_P_REC_FRAC  = 4'd4;
    localparam logic [3:0] DEF_K_WIND_FRAC = 4'd4;
    localparam logic [3:0] DEF_K_ACT_FRAC  = 4'd4;
    localparam logic [3:0] DEF_K_REC_FRAC  = 4'd2;
    localparam logic [3:0] DEF_STUN_FRAC   = 4'd1;

    localparam logic [3:0] COMBO_MAX = 4'd15;

endpackage

// File: rtl/attack_req_buffer.sv
// attack_req_buffer
// One-deep buffer holding the first punch/kick request seen while the combo
// window is open. Only built when ATTACK_COMBO_EN is defined; without the
// macro this file contributes no module.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   capture        : window open, a request this cycle may be stored
//   req_punch      : punch request (wins over kick in the same cycle)
//   req_kick       : kick request
//   clear          : empty the buffer (takes precedence over capture)
//   full           : buffer holds a request
//   req_type       : stored attack type
`ifdef ATTACK_COMBO_EN
module attack_req_buffer
    import attack_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    capture,
    input  logic    req_punch,
    input  logic    req_kick,
    input  logic    clear,
    output logic    full,
    output attack_e req_type
);

    logic    full_q, full_d;
    attack_e type_q, type_d;

    // Only the first request is kept; later ones are dropped while full.
    always_comb begin
        full_d = full_q;
        type_d = type_q;
        if (clear) begin
            full_d = 1'b0;
            type_d = ATK_NONE;
        end else if (capture && !full_q && (req_punch || req_kick)) begin
            full_d = 1'b1;
            type_d = req_punch ? ATK_PUNCH : ATK_KICK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            type_q <= ATK_NONE;
        end else begin
            full_q <= full_d;
            type_q <= type_d;
        end
    end

    assign full     = full_q;
    assign req_type = type_q;

endmodule
`endif

// File: rtl/attack_phase_sequencer.sv
// attack_phase_sequencer
// Steps one fighter's attack through WINDUP -> ACTIVE -> RECOVERY, and
// through ABORT -> STUN when hit, driving an external fraction-second timer.
// Optional combo buffering is enabled by defining ATTACK_COMBO_EN.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   punch, kick, hit      : one-cycle request / hit pulses
//   tmr_done/running/halfway : timer status inputs
//   tmr_start, tmr_fraction, tmr_clear : timer control outputs
//   phase, attack_type    : current phase and attack type
//   hitbox_active, busy   : phase-derived flags
//   combo_count           : combo counter (0 without ATTACK_COMBO_EN)
module attack_phase_sequencer
    import attack_pkg::*;
#(
    parameter logic [3:0] P_WIND_FRAC = DEF_P_WIND_FRAC,
    parameter logic [3:0] P_ACT_FRAC  = DEF_P_ACT_FRAC,
    parameter logic [3:0] P_REC_FRAC  = DEF_P_REC_FRAC,
    parameter logic [3:0] K_WIND_FRAC = DEF_K_WIND_FRAC,
    parameter logic [3:0] K_ACT_FRAC  = DEF_K_ACT_FRAC,
    parameter logic [3:0] K_REC_FRAC  = DEF_K_REC_FRAC,
    parameter logic [3:0] STUN_FRAC   = DEF_STUN_FRAC
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       punch,
    input  logic       kick,
    input  logic       hit,
    input  logic       tmr_done,
    input  logic       tmr_running,
    input  logic       tmr_halfway,
    output logic       tmr_start,
    output logic [3:0] tmr_fraction,
    output logic       tmr_clear,
    output logic [2:0] phase,
    output logic [1:0] attack_type,
    output logic       hitbox_active,
    output logic       busy,
    output logic [3:0] combo_count
);

    phase_e     phase_q, phase_d;
    attack_e    type_q, type_d;
    logic       start_q, start_d;
    logic [3:0] frac_q, frac_d;
    logic       clear_q, clear_d;
    logic       hitbox_q, hitbox_d;
    logic       busy_q, busy_d;
    logic       done_ok;

    function automatic logic [3:0] frac_for(input phase_e ph, input attack_e ty);
        logic [3:0] f;
        f = 4'd0;
        case (ph)
            PH_WINDUP:   f = (ty == ATK_KICK) ? K_WIND_FRAC : P_WIND_FRAC;
            PH_ACTIVE:   f = (ty == ATK_KICK) ? K_ACT_FRAC  : P_ACT_FRAC;
            PH_RECOVERY: f = (ty == ATK_KICK) ? K_REC_FRAC  : P_REC_FRAC;
            PH_STUN:     f = STUN_FRAC;
            default:     f = 4'd0;
        endcase
        return f;
    endfunction

    // A done pulse seen while start is still raised belongs to a stale run.
    assign done_ok = tmr_done && !start_q;

`ifdef ATTACK_COMBO_EN
    logic       half_seen_q, half_seen_d;
    logic [3:0] combo_q, combo_d;
    logic       buf_capture, buf_clear, buf_full;
    attack_e    buf_type;

    // Requests are buffered only in RECOVERY once the halfway pulse was seen.
    assign buf_capture = (phase_q == PH_RECOVERY) && half_seen_q;

    attack_req_buffer u_req_buffer (
        .clk       (clk),
        .reset     (reset),
        .capture   (buf_capture),
        .req_punch (punch),
        .req_kick  (kick),
        .clear     (buf_clear),
        .full      (buf_full),
        .req_type  (buf_type)
    );
`else
    logic unused_halfway;
    assign unused_halfway = tmr_halfway;
`endif

    // Next-state logic; every phase entry loads a fraction and raises start,
    // and start falls once the timer reports running.
    always_comb begin
        phase_d = phase_q;
        type_d  = type_q;
        start_d = start_q;
        frac_d  = frac_q;
        clear_d = 1'b0;
`ifdef ATTACK_COMBO_EN
        half_seen_d = half_seen_q;
        combo_d     = combo_q;
        buf_clear   = 1'b0;
`endif
        if (start_q && tmr_running) begin
            start_d = 1'b0;
        end

        case (phase_q)
            PH_IDLE: begin
                if (punch || kick) begin
                    phase_d = PH_WINDUP;
                    type_d  = punch ? ATK_PUNCH : ATK_KICK;
                    start_d = 1'b1;
                    frac_d  = frac_for(PH_WINDUP, punch ? ATK_PUNCH : ATK_KICK);
                end
            end
            PH_WINDUP, PH_ACTIVE, PH_RECOVERY: begin
                if (hit) begin
                    phase_d = PH_ABORT;
                    clear_d = 1'b1;
                    start_d = 1'b0;
`ifdef ATTACK_COMBO_EN
                    buf_clear   = 1'b1;
                    half_seen_d = 1'b0;
                    combo_d     = 4'd0;
`endif
                end else if (done_ok) begin
                    if (phase_q == PH_WINDUP) begin
                        phase_d = PH_ACTIVE;
                        start_d = 1'b1;
                        frac_d  = frac_for(PH_ACTIVE, type_q);
                    end else if (phase_q == PH_ACTIVE) begin
                        phase_d = PH_RECOVERY;
                        start_d = 1'b1;
                        frac_d  = frac_for(PH_RECOVERY, type_q);
                    end else begin
                        phase_d = PH_IDLE;
                        type_d  = ATK_NONE;
                        start_d = 1'b0;
                        frac_d  = 4'd0;
`ifdef ATTACK_COMBO_EN
                        buf_clear   = 1'b1;
                        half_seen_d = 1'b0;
                        combo_d     = 4'd0;
                        if (buf_full) begin
                            phase_d = PH_WINDUP;
                            type_d  = buf_type;
                            start_d = 1'b1;
                            frac_d  = frac_for(PH_WINDUP, buf_type);
                            combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + 4'd1;
                        end
`endif
                    end
                end
`ifdef ATTACK_COMBO_EN
                else if (phase_q == PH_RECOVERY && tmr_halfway) begin
                    half_seen_d = 1'b1;
                end
`endif
            end
            PH_ABORT: begin
                phase_d = PH_STUN;
                type_d  = ATK_NONE;
                start_d = 1'b1;
                frac_d  = frac_for(PH_STUN, ATK_NONE);
            end
            PH_STUN: begin
                if (done_ok) begin
                    phase_d = PH_IDLE;
                    start_d = 1'b0;
                    frac_d  = 4'd0;
                end
            end
            default: begin
                phase_d = PH_IDLE;
                type_d  = ATK_NONE;
                start_d = 1'b0;
                frac_d  = 4'd0;
            end
        endcase

        hitbox_d = (phase_d == PH_ACTIVE);
        busy_d   = (phase_d != PH_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_IDLE;
            type_q   <= ATK_NONE;
            start_q  <= 1'b0;
            frac_q   <= 4'd0;
            clear_q  <= 1'b0;
            hitbox_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            type_q   <= type_d;
            start_q  <= start_d;
            frac_q   <= frac_d;
            clear_q  <= clear_d;
            hitbox_q <= hitbox_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ATTACK_COMBO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_seen_q <= 1'b0;
            combo_q     <= 4'd0;
        end else begin
            half_seen_q <= half_seen_d;
            combo_q     <= combo_d;
        end
    end

    assign combo_count = combo_q;
`else
    assign combo_count = 4'd0;
`endif

    assign phase         = phase_q;
    assign attack_type   = type_q;
    assign tmr_start     = start_q;
    assign tmr_fraction  = frac_q;
    assign tmr_clear     = clear_q;
    assign hitbox_active = hitbox_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_attack_phase_sequencer.sv
// tb_attack_phase_sequencer
// Directed bench for attack_phase_sequencer with a behavioural
// fraction-second timer (CLOCK_FREQ=64). With that timer a phase using
// fraction F lasts 64/F + 2 cycles: one cycle for the timer to see start,
// 64/F running cycles, and one cycle for the done pulse.
// Combo scenarios are compiled only when ATTACK_COMBO_EN is defined.
module tb_attack_phase_sequencer;

    localparam int CLOCK_FREQ = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       punch = 1'b0;
    logic       kick = 1'b0;
    logic       hit = 1'b0;
    logic       tmr_done, tmr_running, tmr_halfway;
    logic       tmr_start;
    logic [3:0] tmr_fraction;
    logic       tmr_clear;
    logic [2:0] phase;
    logic [1:0] attack_type;
    logic       hitbox_active;
    logic       busy;
    logic [3:0] combo_count;

    int checks = 0;
    int failures = 0;
    int n;

    // Clock generation
    always #5 clk = ~clk;

    attack_phase_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .punch         (punch),
        .kick          (kick),
        .hit           (hit),
        .tmr_done      (tmr_done),
        .tmr_running   (tmr_running),
        .tmr_halfway   (tmr_halfway),
        .tmr_start     (tmr_start),
        .tmr_fraction  (tmr_fraction),
        .tmr_clear     (tmr_clear),
        .phase         (phase),
        .attack_type   (attack_type),
        .hitbox_active (hitbox_active),
        .busy          (busy),
        .combo_count   (combo_count)
    );

    // Behavioural fraction timer: start is ignored while running, clear is a
    // synchronous reset, and the system reset clears it asynchronously.
    int t_cnt, t_len;
    always @(posedge clk or negedge reset) begin
        if (!reset || tmr_clear) begin
            tmr_running <= 1'b0;
            tmr_done    <= 1'b0;
            tmr_halfway <= 1'b0;
            t_cnt       <= 0;
            t_len       <= 0;
        end else begin
            tmr_done    <= 1'b0;
            tmr_halfway <= 1'b0;
            if (!tmr_running) begin
                if (tmr_start && tmr_fraction != 4'd0) begin
                    tmr_running <= 1'b1;
                    t_len       <= CLOCK_FREQ / int'(tmr_fraction);
                    t_cnt       <= CLOCK_FREQ / int'(tmr_fraction) - 1;
                end
            end else begin
                if (t_cnt == t_len / 2 - 1) tmr_halfway <= 1'b1;
                if (t_cnt == 0) begin
                    tmr_running <= 1'b0;
                    tmr_done    <= 1'b1;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the request/hit inputs, sampled by the next edge.
    task automatic applyStimulus(input logic p, input logic k, input logic h);
        punch = p;
        kick  = k;
        hit   = h;
        tick();
        punch = 1'b0;
        kick  = 1'b0;
        hit   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until phase reaches target; a budget overrun returns the budget.
    task automatic wait_phase(input logic [2:0] target, input int budget, output int cycles);
        cycles = 0;
        while (phase !== target && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_phase"}, 32'(phase), 0);
        checkOutput({tag, "_type"}, 32'(attack_type), 0);
        checkOutput({tag, "_start"}, 32'(tmr_start), 0);
        checkOutput({tag, "_frac"}, 32'(tmr_fraction), 0);
        checkOutput({tag, "_clear"}, 32'(tmr_clear), 0);
        checkOutput({tag, "_hitbox"}, 32'(hitbox_active), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_combo"}, 32'(combo_count), 0);
    endtask

    initial begin
        // Reset state
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Punch: WINDUP 8+2, ACTIVE 8+2, RECOVERY 16+2 cycles
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("p_phase", 32'(phase), 1);
        checkOutput("p_type", 32'(attack_type), 1);
        checkOutput("p_start", 32'(tmr_start), 1);
        checkOutput("p_busy", 32'(busy), 1);
        checkOutput("p_frac", 32'(tmr_fraction), 8);
        checkOutput("p_hitbox_wind", 32'(hitbox_active), 0);
        tick();
        checkOutput("p_start_2nd", 32'(tmr_start), 1);
        tick();
        checkOutput("p_start_drop", 32'(tmr_start), 0);
        wait_phase(3'd2, 100, n);
        checkOutput("p_wind_len", 32'(n), 8);
        checkOutput("p_hitbox_act", 32'(hitbox_active), 1);
        checkOutput("p_act_frac", 32'(tmr_fraction), 8);
        wait_phase(3'd3, 100, n);
        checkOutput("p_act_len", 32'(n), 10);
        checkOutput("p_hitbox_rec", 32'(hitbox_active), 0);
        checkOutput("p_rec_frac", 32'(tmr_fraction), 4);
        wait_phase(3'd0, 100, n);
        checkOutput("p_rec_len", 32'(n), 18);
        checkOutput("p_idle_type", 32'(attack_type), 0);
        checkOutput("p_idle_busy", 32'(busy), 0);

        // Punch and kick together: punch wins
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("pk_type", 32'(attack_type), 1);
        checkOutput("pk_frac", 32'(tmr_fraction), 8);
        wait_phase(3'd0, 200, n);
        checkOutput("pk_total_len", 32'(n), 38);

        // Kick, hit mid-ACTIVE, second hit during STUN ignored
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("k_type", 32'(attack_type), 2);
        checkOutput("k_frac", 32'(tmr_fraction), 4);
        wait_phase(3'd2, 100, n);
        checkOutput("k_wind_len", 32'(n), 18);
        repeat (5) tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("hit_abort", 32'(phase), 4);
        checkOutput("hit_clear", 32'(tmr_clear), 1);
        checkOutput("hit_hitbox", 32'(hitbox_active), 0);
        tick();
        checkOutput("stun_phase", 32'(phase), 5);
        checkOutput("stun_clear", 32'(tmr_clear), 0);
        checkOutput("stun_start", 32'(tmr_start), 1);
        checkOutput("stun_frac", 32'(tmr_fraction), 1);
        checkOutput("stun_type", 32'(attack_type), 0);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stun_rehit_phase", 32'(phase), 5);
        checkOutput("stun_rehit_clear", 32'(tmr_clear), 0);
        wait_phase(3'd0, 200, n);
        checkOutput("stun_remaining", 32'(n), 55);

        // Kick during WINDUP is dropped
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drop_phase", 32'(phase), 1);
        checkOutput("drop_type", 32'(attack_type), 1);
        wait_phase(3'd2, 100, n);
        checkOutput("drop_wind_rest", 32'(n), 6);
        checkOutput("drop_act_type", 32'(attack_type), 1);
        wait_phase(3'd0, 100, n);
        checkOutput("drop_rest_len", 32'(n), 28);

`ifdef ATTACK_COMBO_EN
        // Early punch in RECOVERY dropped, kick after halfway chains a combo
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_phase(3'd3, 100, n);
        checkOutput("c_to_rec", 32'(n), 20);
        repeat (2) tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("c_early_phase", 32'(phase), 3);
        repeat (9) tick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_phase(3'd1, 100, n);
        checkOutput("c_rec_rest", 32'(n), 5);
        checkOutput("c_type", 32'(attack_type), 2);
        checkOutput("c_count", 32'(combo_count), 1);
        checkOutput("c_frac", 32'(tmr_fraction), 4);
        checkOutput("c_start", 32'(tmr_start), 1);
        wait_phase(3'd0, 200, n);
        checkOutput("c_kick_len", 32'(n), 70);
        checkOutput("c_idle_count", 32'(combo_count), 0);
`endif

        // Reset mid-RECOVERY, then a clean punch
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_phase(3'd3, 100, n);
        checkOutput("r_to_rec", 32'(n), 20);
        repeat (3) tick();
        #1;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("r_phase", 32'(phase), 1);
        checkOutput("r_type", 32'(attack_type), 1);
        checkOutput("r_start", 32'(tmr_start), 1);
        checkOutput("r_frac", 32'(tmr_fraction), 8);
        wait_phase(3'd0, 200, n);
        checkOutput("r_total_len", 32'(n), 38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
